// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and load/store requesters.
// Policy macro: MEM_ARB_RR_EN (defined = round-robin, undefined = LS fixed priority).
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic if_req_i,
   input  logic ls_req_i,
   input  logic last_served_i,
   output logic valid_o,
   output logic winner_o
);

   assign valid_o = if_req_i | ls_req_i;

`ifdef MEM_ARB_RR_EN
   // On contention the side that was not served last wins; otherwise the lone requester.
   always_comb begin
      winner_o = OWN_IF;
      if (if_req_i && ls_req_i)
         winner_o = (last_served_i == OWN_LS) ? OWN_IF : OWN_LS;
      else if (ls_req_i)
         winner_o = OWN_LS;
   end
`else
   // History is irrelevant under fixed priority; the register feeding it gets pruned.
   logic unused_last_served;
   assign unused_last_served = last_served_i;

   // Load/store always beats fetch.
   assign winner_o = ls_req_i ? OWN_LS : OWN_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and load/store.
// One transaction in flight: IDLE/RESP arbitrate, ISSUE strobes memory,
// WAIT counts MEM_LAT cycles, RESP returns data to the owner.
// Policy macro: MEM_ARB_RR_EN (evaluated only inside mem_arb_pick).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_LAT = 1   // 1..15
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

   arb_state_e  state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_served_q, last_served_d;
   logic        store_q, store_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;
   logic        pick_valid, pick_winner;
   logic        owner_req;

   mem_arb_pick u_pick (
      .if_req_i      (if_req),
      .ls_req_i      (ls_req),
      .last_served_i (last_served_q),
      .valid_o       (pick_valid),
      .winner_o      (pick_winner)
   );

   assign owner_req = (owner_q == OWN_LS) ? ls_req : if_req;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;

   // Next-state and output decode; every output idles at zero.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_served_d = last_served_q;
      store_d       = store_q;
      cnt_d         = cnt_q;
      if_rdata_d    = if_rdata_q;
      ls_rdata_d    = ls_rdata_q;
      if_gnt        = 1'b0;
      ls_gnt        = 1'b0;
      if_rvalid     = 1'b0;
      ls_rvalid     = 1'b0;
      mem_en        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      case (state_q)
         IDLE, RESP: begin
            if (state_q == RESP) begin
               if (owner_q == OWN_LS) ls_rvalid = 1'b1;
               else                   if_rvalid = 1'b1;
            end
            if (pick_valid) begin
               owner_d = pick_winner;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            // A requester that dropped its request before the grant is withdrawn.
            if (!owner_req) begin
               state_d = IDLE;
            end else begin
               mem_en        = 1'b1;
               mem_wdata     = ls_wdata;
               cnt_d         = CNT_LOAD;
               last_served_d = owner_q;
               state_d       = WAIT;
               if (owner_q == OWN_LS) begin
                  ls_gnt   = 1'b1;
                  mem_we   = ls_we;
                  mem_addr = ls_addr;
                  store_d  = ls_we;
               end else begin
                  if_gnt   = 1'b1;
                  mem_addr = if_addr;
                  store_d  = 1'b0;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               if (owner_q == OWN_LS) ls_rdata_d = store_q ? 32'h0 : mem_rdata;
               else                   if_rdata_d = mem_rdata;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_q       <= OWN_IF;
         last_served_q <= OWN_LS;
         store_q       <= 1'b0;
         cnt_q         <= 4'd0;
         if_rdata_q    <= 32'h0;
         ls_rdata_q    <= 32'h0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_served_q <= last_served_d;
         store_q       <= store_d;
         cnt_q         <= cnt_d;
         if_rdata_q    <= if_rdata_d;
         ls_rdata_q    <= ls_rdata_d;
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req  input  1  instruction-fetch read request; held until if_gnt.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_gnt  output  1  one-cycle pulse; fetch request accepted.
REQ-007 if_rvalid  output  1  one-cycle pulse; if_rdata valid.
REQ-008 if_rdata  output  32  fetched instruction word.
REQ-009 ls_req  input  1  load/store request; held until ls_gnt.
REQ-010 ls_we  input  1  1 = store, 0 = load.
REQ-011 ls_addr  input  32  load/store byte address.
REQ-012 ls_wdata  input  32  store data.
REQ-013 ls_gnt  output  1  one-cycle pulse; load/store accepted.
REQ-014 ls_rvalid  output  1  one-cycle pulse; load data valid or store complete.
REQ-015 ls_rdata  output  32  load data; 0 for stores.
REQ-016 mem_en  output  1  memory access strobe, one cycle per transaction.
REQ-017 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-018 mem_addr  output  32  memory address; mem_wdata output 32, store data; mem_rdata input 32, read data.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP; one transaction in flight at most.
REQ-020 Arbitration is evaluated in IDLE and RESP; if any req is high, the winner is latched as owner and the next state is ISSUE; otherwise the next state is IDLE.
REQ-021 ISSUE: for one cycle, drive owner gnt=1, mem_en=1, mem_addr and mem_we from the owner (mem_we=0 for fetch), and mem_wdata=ls_wdata; next state is WAIT.
REQ-022 WAIT lasts exactly MEM_LAT cycles via a 4-bit down-counter loaded with MEM_LAT-1 in ISSUE; mem_rdata is captured on the last WAIT cycle; next state is RESP.
REQ-023 RESP: for one cycle, owner rvalid=1 and owner rdata=captured word; the non-owner rdata holds its last value.
REQ-024 Latency: a request seen in IDLE at cycle T gets gnt at T+1, mem_en at T+1, and rvalid at T+2+MEM_LAT; back-to-back throughput is one transaction per MEM_LAT+2 cycles.
REQ-025 When inactive, mem_en, mem_we, gnt, and rvalid are 0; mem_addr and mem_wdata are 0 outside ISSUE.
REQ-026 A req deasserted before gnt is withdrawn; no transaction is issued for it.
REQ-027 Simultaneous if_req and ls_req are resolved per REQ-033/REQ-034; the loser stays pending and never receives gnt in the same cycle.

Reset
REQ-028 rst forces IDLE, counter 0, owner=IF, last-served=LS, and all outputs 0 on the next edge.
REQ-029 rst mid-transaction (ISSUE, WAIT, or RESP) aborts the transaction; no rvalid is produced for it.
REQ-030 rst has priority over all other inputs.

Configuration
REQ-031 Macro MEM_ARB_RR_EN selects the arbitration policy.
REQ-032 The policy only changes the winner selection; timing is unchanged.
REQ-033 MEM_ARB_RR_EN defined: round-robin; on contention, the requester not served last wins; last-served updates in ISSUE.
REQ-034 MEM_ARB_RR_EN undefined: fixed priority; ls_req always beats if_req; the last-served register is not built.

Structure
REQ-035 Shared package mem_arb_pkg holds the state enum (IDLE/ISSUE/WAIT/RESP) and owner constants OWN_IF=0 and OWN_LS=1.
REQ-036 One combinational sub-module, mem_arb_pick, takes if_req, ls_req, and last_served and returns valid and winner; the policy macro is evaluated only inside it.

Verification
REQ-037 MEM_LAT=2, if_req with if_addr=0x10 at T, mem_rdata=0xDEADBEEF at T+3 -> if_gnt at T+1, mem_addr=0x10, if_rvalid at T+4 with if_rdata=0xDEADBEEF.
REQ-038 Store: ls_we=1, ls_addr=0x200, ls_wdata=0x12345678 -> one cycle of mem_en=1, mem_we=1 with those values; ls_rvalid pulses 2+MEM_LAT cycles after the request; ls_rdata=0.
REQ-039 Both reqs held continuously, RR build -> grants alternate IF, LS, IF, LS starting with IF; fixed build -> LS every time and IF starved.
REQ-040 rst asserted during WAIT -> next cycle IDLE with all outputs 0; no rvalid ever appears for the aborted access.
REQ-041 if_req pulsed for one cycle while LS owns the port -> no if_gnt and no fetch issued.
REQ-042 MEM_LAT=1 and MEM_LAT=15 back-to-back fetches -> rvalid spacing of 3 and 17 cycles respectively.
